// File: rtl/reg_file_32x64.sv
// ID-stage integer register file: 31 x 64-bit storage + hard-wired XZR,
// two combinational read ports with WB write-through, one write port.
module reg_file_32x64 #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int ZR_IDX = 31
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [ADDR_W-1:0] RA1,
    input  logic [ADDR_W-1:0] RA2,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WA,
    input  logic [DATA_W-1:0] WD
);

    localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZR_IDX);

    logic [DATA_W-1:0] regs_q [ZR_IDX];
    logic              wr_en;

    assign wr_en = RegWrite && (WA != ZR);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < ZR_IDX; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[WA] <= WD;
        end
    end

    // XZR first, then same-cycle WB data, then storage; reset forces zero.
    function automatic logic [DATA_W-1:0] rd_mux(
        input logic [ADDR_W-1:0] ra,
        input logic              rst_n,
        input logic              we,
        input logic [ADDR_W-1:0] wa,
        input logic [DATA_W-1:0] wd,
        input logic [DATA_W-1:0] stored
    );
        logic [DATA_W-1:0] r;
        r = '0;
        if (!rst_n || ra == ZR) begin
            r = '0;
        end else if (we && wa == ra) begin
            r = wd;
        end else begin
            r = stored;
        end
        return r;
    endfunction

    logic [DATA_W-1:0] st1, st2;

    always_comb begin
        st1 = '0;
        st2 = '0;
        if (RA1 != ZR) st1 = regs_q[RA1];
        if (RA2 != ZR) st2 = regs_q[RA2];
    end

    assign RD1 = rd_mux(RA1, RESET_N, wr_en, WA, WD, st1);
    assign RD2 = rd_mux(RA2, RESET_N, wr_en, WA, WD, st2);

endmodule

// File: tb/tb_reg_file_32x64.sv
// Scoreboard bench for reg_file_32x64: stimulus queues expected read data,
// a negedge monitor pops and compares against RD1/RD2.
module tb_reg_file_32x64;

    logic        clk;
    logic        rst_n;
    logic [4:0]  ra1, ra2, wa;
    logic [63:0] rd1, rd2, wd;
    logic        rw;

    typedef struct {
        string       name;
        logic [63:0] e1;
        logic [63:0] e2;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    reg_file_32x64 dut (
        .CLK(clk), .RESET_N(rst_n),
        .RA1(ra1), .RA2(ra2),
        .RD1(rd1), .RD2(rd2),
        .RegWrite(rw), .WA(wa), .WD(wd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (rd1 !== e.e1) begin
                errors++;
                $display("FAIL %s RD1 got %h want %h", e.name, rd1, e.e1);
            end
            checks++;
            if (rd2 !== e.e2) begin
                errors++;
                $display("FAIL %s RD2 got %h want %h", e.name, rd2, e.e2);
            end
        end
    end

    task automatic push(input string n, input logic [63:0] e1,
                        input logic [63:0] e2);
        exp_t e;
        e.name = n;
        e.e1 = e1;
        e.e2 = e2;
        sb.push_back(e);
    endtask

    task automatic vec(input string n, input logic r,
                       input logic [4:0] a1, input logic [4:0] a2,
                       input logic w, input logic [4:0] wad,
                       input logic [63:0] wdat,
                       input logic [63:0] e1, input logic [63:0] e2);
        @(posedge clk);
        #1;
        rst_n = r;
        ra1 = a1;
        ra2 = a2;
        rw = w;
        wa = wad;
        wd = wdat;
        push(n, e1, e2);
    endtask

    function automatic logic [63:0] xzr_exp(input int i);
        case (i)
            5:       return 64'h0123_4567_89AB_CDEF;
            6:       return 64'hFFFF_FFFF_FFFF_FFFF;
            default: return 64'h0;
        endcase
    endfunction

    initial begin
        rst_n = 1'b0;
        ra1 = '0; ra2 = '0; rw = 1'b0; wa = '0; wd = '0;
        repeat (2) @(posedge clk);

        vec("rst_hold", 0, 0, 31, 1, 2, 64'hFF, 0, 0);
        vec("no_wr_in_rst", 1, 2, 2, 0, 0, 0, 0, 0);
        vec("wr_x1", 1, 1, 0, 1, 1, 64'h5, 64'h5, 0);
        vec("rd_x1", 1, 1, 1, 0, 0, 0, 64'h5, 64'h5);

        @(posedge clk);
        #1;
        ra1 = 1; ra2 = 1; rw = 1'b1; wa = 1; wd = 64'h77;
        #2;
        rst_n = 1'b0;
        push("async_clr", 0, 0);
        for (int i = 0; i < 32; i++) begin
            vec("rst_sweep", 1, 5'(i), 5'(31 - i), 0, 0, 0, 0, 0);
        end

        vec("wr_x5", 1, 0, 5, 1, 5, 64'h0123_4567_89AB_CDEF,
            0, 64'h0123_4567_89AB_CDEF);
        vec("rd_x5", 1, 5, 5, 0, 0, 0,
            64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);
        vec("wr_x6", 1, 5, 6, 1, 6, 64'hFFFF_FFFF_FFFF_FFFF,
            64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF);
        vec("x5_kept", 1, 5, 6, 0, 0, 0,
            64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF);

        vec("xzr_wr", 1, 31, 31, 1, 31, 64'hDEAD_BEEF_DEAD_BEEF, 0, 0);
        vec("xzr_after", 1, 31, 31, 0, 0, 0, 0, 0);
        for (int i = 0; i < 31; i++) begin
            vec("xzr_sweep", 1, 5'(i), 5'(30 - i), 0, 0, 0,
                xzr_exp(i), xzr_exp(30 - i));
        end

        vec("wr_x7", 1, 8, 7, 1, 7, 64'h11, 0, 64'h11);
        vec("x7_old", 1, 8, 7, 0, 0, 0, 0, 64'h11);
        vec("byp_x7", 1, 8, 7, 1, 7, 64'h22, 0, 64'h22);
        vec("x7_new", 1, 8, 7, 0, 0, 0, 0, 64'h22);
        vec("byp_both", 1, 9, 9, 1, 9, 64'h33, 64'h33, 64'h33);
        vec("x9_both", 1, 9, 9, 0, 0, 0, 64'h33, 64'h33);

        vec("wr_x12", 1, 0, 0, 1, 12, 64'hAAAA, 0, 0);
        vec("wr_x20", 1, 0, 0, 1, 20, 64'h5555, 0, 0);
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0)
                vec("r2l_rm", 1, 20, 12, 0, 0, 0, 64'h5555, 64'hAAAA);
            else
                vec("r2l_rt", 1, 12, 20, 0, 0, 0, 64'hAAAA, 64'h5555);
        end

        for (int i = 0; i < 31; i++) begin
            vec("fill", 1, 5'(i), 5'(i), 1, 5'(i), 64'(i),
                64'(i), 64'(i));
        end
        vec("fill_chk", 1, 3, 30, 0, 0, 0, 64'd3, 64'd30);

        @(posedge clk);
        #1;
        ra1 = 3; ra2 = 4; rw = 1'b1; wa = 3; wd = 64'h99;
        rst_n = 1'b0;
        push("rst_on_wr", 0, 0);
        for (int i = 0; i < 32; i++) begin
            vec("post_rst", 1, 5'(i), 5'(31 - i), 0, 0, 0, 0, 0);
        end

        begin
            int budget = 10;
            while (sb.size() > 0 && budget > 0) begin
                @(posedge clk);
                budget--;
            end
            if (sb.size() > 0) begin
                errors++;
                $display("FAIL drain left %0d want 0", sb.size());
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file_32x64.md
Name: reg_file_32x64

Overview:
- ARMv8 integer register file in the ID stage of the pipelined core: 32 x 64-bit registers, two combinational read ports, one synchronous write port.
- Read port 2 address (RA2) is driven directly by the 5-bit Reg2Loc 2:1 mux that selects between the Rm and Rt instruction fields.
- Write port is driven by the WB stage.
- Register 31 is XZR: it always reads zero and ignores writes.
- WB-to-ID write-through bypass removes the same-cycle read-after-write hazard.

Parameters:
- DATA_W, 64, register width in bits.
- ADDR_W, 5, register address width.
- ZR_IDX, 31, index of the hard-wired zero register (XZR).

Ports:
- CLK  input  1  core clock; all state updates on the rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- RA1  input  ADDR_W  read address 1 (Rn field).
- RA2  input  ADDR_W  read address 2 (output of the Reg2Loc mux: Rm or Rt).
- RD1  output  DATA_W  read data 1.
- RD2  output  DATA_W  read data 2.
- RegWrite  input  1  write enable from WB.
- WA  input  ADDR_W  write address from WB (Rd/Rt).
- WD  input  DATA_W  write data from WB.

Behaviour:
- One clock (CLK). Reset is asynchronous and active-low (RESET_N).
- Storage: regs[0..30], each DATA_W bits. Index 31 has no storage.
- Reset:
  - RESET_N low clears regs[0..30] to 0 immediately, without waiting for a clock edge.
  - While RESET_N is low, RD1 = RD2 = 0 and writes are ignored.
  - Reset deasserting mid-cycle takes effect at the next CLK rising edge; no write occurs on the edge where RESET_N is still low.
- Write:
  - On a CLK rising edge with RESET_N high, RegWrite = 1 and WA != ZR_IDX: regs[WA] <= WD.
  - RegWrite = 1 with WA = ZR_IDX is a no-op.
- Read (combinational, zero latency), evaluated independently for each port p in {1,2}:
  - RAp = ZR_IDX -> RDp = 0, regardless of any write activity.
  - Else if RegWrite = 1 and WA = RAp -> RDp = WD (write-through bypass; the combinational path covers same-cycle WB/ID overlap).
  - Else -> RDp = regs[RAp].
- Both ports may read the same address; both see identical data, including the bypass.
- Bypass uses only the current-cycle WA/WD/RegWrite; there is no multi-cycle forwarding (EX/MEM forwarding lives in the forwarding unit).
- X/undefined RA: no requirement beyond no state corruption.
- No stall or flush inputs; the pipeline stalls by holding RA1/RA2 and deasserting RegWrite.
- No internal state machine beyond the storage array; exactly one write per cycle maximum.

Test Plan:
- Reset: pulse RESET_N low asynchronously between clock edges, then sweep RA1/RA2 over 0..31 -> every read returns 0x0000_0000_0000_0000.
- Write/read: write X5 = 0x0123_4567_89AB_CDEF, deassert RegWrite, set RA1 = 5 and RA2 = 5 -> RD1 = RD2 = 0x0123_4567_89AB_CDEF. Then write X6 = 0xFFFF_FFFF_FFFF_FFFF -> X5 unchanged.
- XZR:
  - Write WA = 31, WD = 0xDEAD_BEEF_DEAD_BEEF with RegWrite = 1 -> RA1 = 31 returns 0 both during the write cycle and afterwards.
  - Full sweep of 0..30 shows no register changed.
- Bypass:
  - X7 holds 0x11. Set RegWrite = 1, WA = 7, WD = 0x22, and RA2 = 7 in the same cycle -> RD2 = 0x22 before the clock edge.
  - After the edge, with RegWrite = 0 -> RD2 = 0x22.
  - With RA1 = 8 in the same cycle -> RD1 unaffected by the bypass.
- Reset mid-operation:
  - Fill X0..X30 with their index values, assert RESET_N low coincident with a write (WA = 3, WD = 0x99) -> no write lands.
  - After release, all registers read 0.
- Reg2Loc path: drive RA2 alternately from Rm = 12 and Rt = 20, with X12 = 0xAAAA and X20 = 0x5555 -> RD2 tracks 0xAAAA / 0x5555 in the same cycle the address changes.
